// File: rtl/mbist_ctrl_if.sv
// mbist_ctrl_if: bundles the March C- BIST controller's bus-side signals.
//   master : the BIST controller (drives the bist_* request stream, mode and results)
//   slave  : environment side (drives bist_start and the memory read data)
// Signals:
//   bist_start  run request level       mem_dout   memory read data (1-cycle latency)
//   mode        mux select, 1 = BIST    bist_cs    chip select
//   bist_we     1 = write, 0 = read     bist_addr  operation address
//   bist_pat    write / expected data   bist_done  test finished (level)
//   bist_fail   sticky mismatch flag    fail_addr  first failing address
//   fail_elem   first failing March element (0..5)
interface mbist_ctrl_if #(
  parameter int unsigned pADDR_WIDTH = 4,
  parameter int unsigned pDATA_WIDTH = 2
);
  logic                   bist_start;
  logic [pDATA_WIDTH-1:0] mem_dout;
  logic                   mode;
  logic                   bist_cs;
  logic                   bist_we;
  logic [pADDR_WIDTH-1:0] bist_addr;
  logic [pDATA_WIDTH-1:0] bist_pat;
  logic                   bist_done;
  logic                   bist_fail;
  logic [pADDR_WIDTH-1:0] fail_addr;
  logic [2:0]             fail_elem;

  modport master (
    input  bist_start, mem_dout,
    output mode, bist_cs, bist_we, bist_addr, bist_pat,
           bist_done, bist_fail, fail_addr, fail_elem
  );

  modport slave (
    output bist_start, mem_dout,
    input  mode, bist_cs, bist_we, bist_addr, bist_pat,
           bist_done, bist_fail, fail_addr, fail_elem
  );
endinterface

// File: rtl/mbist_ctrl.sv
// mbist_ctrl: March C- memory BIST controller.
// Sequences M0..M5 (w0; up r0,w1; up r1,w0; down r0,w1; down r1,w0; up r0) over
// all 2^pADDR_WIDTH words, one operation per clock, checks read data one cycle
// later and reports pass/fail with the first failing address and element.
// Ports:
//   clk    single clock
//   rst_n  synchronous active-low reset
//   bus    mbist_ctrl_if master modport (start/read data in; bist_* stream,
//          mode and results out)
// Configuration:
//   MBIST_STOP_ON_FAIL_EN  when defined, the first detected mismatch ends the run.
module mbist_ctrl #(
  parameter int unsigned pADDR_WIDTH = 4,
  parameter int unsigned pDATA_WIDTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mbist_ctrl_if.master bus
);

  localparam int unsigned AddrW = pADDR_WIDTH;
  localparam int unsigned DataW = pDATA_WIDTH;
  localparam int unsigned ElemW = 3;
  localparam logic [ElemW-1:0] LastElem = ElemW'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ElemW-1:0]   elem_q, elem_d;
  logic               op_q, op_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic               mode_q, mode_d;
  logic               cs_q, cs_d;
  logic               we_q, we_d;
  logic [DataW-1:0]   pat_q, pat_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [AddrW-1:0]   fail_addr_q, fail_addr_d;
  logic [ElemW-1:0]   fail_elem_q, fail_elem_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic [DataW-1:0]   exp_q, exp_d;
  logic [AddrW-1:0]   cmp_addr_q, cmp_addr_d;
  logic [ElemW-1:0]   cmp_elem_q, cmp_elem_d;

  logic               mismatch_c;
  logic [AddrW-1:0]   last_addr_c;

  // M3 and M4 walk the address space downwards.
  function automatic logic elem_desc(input logic [ElemW-1:0] e);
    return (e == ElemW'(3)) || (e == ElemW'(4));
  endfunction

  // M1..M4 issue a read followed by a write at each address.
  function automatic logic elem_two_op(input logic [ElemW-1:0] e);
    return (e >= ElemW'(1)) && (e <= ElemW'(4));
  endfunction

  function automatic logic op_is_write(input logic [ElemW-1:0] e, input logic o);
    if (e == ElemW'(0)) return 1'b1;
    if (e == LastElem)  return 1'b0;
    return o;
  endfunction

  // Data bit of the operation: write value, or expected value for a read.
  function automatic logic op_bit(input logic [ElemW-1:0] e, input logic o);
    if ((e == ElemW'(1)) || (e == ElemW'(3))) return o;
    if ((e == ElemW'(2)) || (e == ElemW'(4))) return ~o;
    return 1'b0;
  endfunction

  assign last_addr_c = elem_desc(elem_q) ? '0 : '1;

  // Read data belongs to the read registered one cycle earlier.
  assign mismatch_c = cmp_vld_q && ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                      (bus.mem_dout != exp_q);

  // Next-state, operation sequencing and result capture.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    cs_d        = cs_q;
    we_d        = we_q;
    pat_d       = pat_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    cmp_vld_d   = cs_q & ~we_q;
    exp_d       = pat_q;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.bist_start) begin
          state_d     = S_ARM;
          mode_d      = 1'b1;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      S_ARM: begin
        state_d = S_RUN;
        cs_d    = 1'b1;
        elem_d  = '0;
        op_d    = 1'b0;
        addr_d  = '0;
      end
      S_RUN: begin
        if (elem_two_op(elem_q) && !op_q) begin
          op_d = 1'b1;
        end else if (addr_q == last_addr_c) begin
          if (elem_q == LastElem) begin
            state_d = S_DRAIN;
            cs_d    = 1'b0;
          end else begin
            elem_d = elem_q + ElemW'(1);
            op_d   = 1'b0;
            addr_d = elem_desc(elem_q + ElemW'(1)) ? '1 : '0;
          end
        end else begin
          op_d   = 1'b0;
          addr_d = elem_desc(elem_q) ? addr_q - AddrW'(1) : addr_q + AddrW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        mode_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE: begin
        if (!bus.bist_start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (mismatch_c) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
`ifdef MBIST_STOP_ON_FAIL_EN
      // Abort: keep the operation registers frozen on the last issued op.
      state_d = S_DONE;
      mode_d  = 1'b0;
      cs_d    = 1'b0;
      done_d  = 1'b1;
      elem_d  = elem_q;
      op_d    = op_q;
      addr_d  = addr_q;
`endif
    end

    // we/pat only move with an issued operation so they hold while idle.
    if (cs_d) begin
      we_d  = op_is_write(elem_d, op_d);
      pat_d = {DataW{op_bit(elem_d, op_d)}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      pat_q       <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      pat_q       <= pat_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.bist_cs   = cs_q;
  assign bus.bist_we   = we_q;
  assign bus.bist_addr = addr_q;
  assign bus.bist_pat  = pat_q;
  assign bus.bist_done = done_q;
  assign bus.bist_fail = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;

endmodule

// File: tb/tb_mbist_ctrl.sv
// tb_mbist_ctrl: scoreboard bench for mbist_ctrl with a faultable memory model.
module tb_mbist_ctrl;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 2;
  localparam int          N    = 1 << AW;
  localparam int          NOPS = 10 * N;

  typedef struct packed {
    logic          mode;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] pat;
  } op_t;

  typedef struct {
    op_t op;
    int  edge_no;
  } exp_op_t;

  typedef struct {
    int            edge_no;
    logic          fail;
    logic [AW-1:0] faddr;
    logic [2:0]    felem;
  } exp_res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbist_ctrl_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  mbist_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  bit done_seen = 1'b0;
  exp_op_t  op_q[$];
  exp_res_t res_q[$];

  // Fault model: kind 0 none, 1 stuck-at-0, 2 stuck-at-1 (applied on read).
  int f_kind = 0;
  int f_addr = 0;
  int f_bit  = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] m;
    if (f_kind == 0 || a != f_addr) return v;
    m = '0;
    m[f_bit] = 1'b1;
    return (f_kind == 1) ? (v & ~m) : (v | m);
  endfunction

  // Memory under test: one-cycle read latency.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_q = '0;
  assign bus.mem_dout = rd_q;
  always @(posedge clk) begin
    if (bus.bist_cs) begin
      if (bus.bist_we) mem[bus.bist_addr] <= bus.bist_pat;
      else rd_q <= apply_fault(mem[bus.bist_addr], int'(bus.bist_addr));
    end
  end

  // Monitor: pops expected ops / results whenever the DUT presents them.
  always @(negedge clk) begin : monitor
    exp_op_t  x;
    exp_res_t r;
    op_t      act;
    if (rst_n) begin
      if (bus.bist_cs) begin
        act = '{mode: bus.mode, we: bus.bist_we, addr: bus.bist_addr, pat: bus.bist_pat};
        if (op_q.size() == 0) begin
          chk("unexpected_op", 64'(act), 64'(0));
        end else begin
          x = op_q.pop_front();
          chk("op_stream", 64'({32'(edge_cnt), act}), 64'({32'(x.edge_no), x.op}));
        end
      end
      if (bus.bist_done && !done_seen) begin
        done_seen = 1'b1;
        if (res_q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          r = res_q.pop_front();
          chk("done_edge", 64'(edge_cnt), 64'(r.edge_no));
          chk("fail_flag", 64'(bus.bist_fail), 64'(r.fail));
          chk("fail_addr", 64'(bus.fail_addr), 64'(r.faddr));
          chk("fail_elem", 64'(bus.fail_elem), 64'(r.felem));
          chk("ops_left", 64'(op_q.size()), 64'(0));
          chk("done_bus_idle", 64'({bus.mode, bus.bist_cs}), 64'(0));
        end
      end
      if (!bus.bist_done) done_seen = 1'b0;
    end
  end

  // Reference model: March C- from its element table, run on an ideal memory
  // with the fault applied; then start the DUT and queue the expectations.
  task automatic start_run(input int kind, input int fa, input int fb, input bit hold,
                           output int e, output exp_res_t res);
    int            rd_v[6] = '{-1, 0, 1, 0, 1, 0};
    int            wr_v[6] = '{ 0, 1, 0, 1, 0, -1};
    op_t           ops[$];
    logic [DW-1:0] ref_mem [N];
    int            first = -1;
    int            nissue;
    op_t           p;
    exp_op_t       xo;
    f_kind = kind; f_addr = fa; f_bit = fb;
    res.fail = 1'b0; res.faddr = '0; res.felem = '0;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = (el == 3 || el == 4) ? (N - 1 - i) : i;
        if (rd_v[el] >= 0) begin
          p = '{mode: 1'b1, we: 1'b0, addr: AW'(a), pat: (rd_v[el] == 1) ? '1 : '0};
          ops.push_back(p);
          if (apply_fault(ref_mem[a], a) !== p.pat && first < 0) begin
            first = ops.size() - 1;
            res.fail = 1'b1; res.faddr = AW'(a); res.felem = 3'(el);
          end
        end
        if (wr_v[el] >= 0) begin
          p = '{mode: 1'b1, we: 1'b1, addr: AW'(a), pat: (wr_v[el] == 1) ? '1 : '0};
          ops.push_back(p);
          ref_mem[a] = p.pat;
        end
      end
    end
    nissue = NOPS;
    @(negedge clk);
    bus.bist_start = 1'b1;
    @(posedge clk);
    #1;
    e = edge_cnt;
    res.edge_no = e + NOPS + 2;
`ifdef MBIST_STOP_ON_FAIL_EN
    if (first >= 0) begin
      nissue = first + 2;
      res.edge_no = e + first + 3;
    end
`endif
    for (int k = 0; k < nissue; k++) begin
      xo.op = ops[k];
      xo.edge_no = e + 1 + k;
      op_q.push_back(xo);
    end
    res_q.push_back(res);
    @(negedge clk);
    chk("start_clears", 64'({bus.bist_fail, bus.fail_addr, bus.fail_elem}), 64'(0));
    if (!hold) bus.bist_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.bist_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(bus.bist_done), 64'(1));
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int       e;
    exp_res_t r;
    int       k;
    bus.bist_start = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.mode, bus.bist_cs, bus.bist_we, bus.bist_addr, bus.bist_pat,
                              bus.bist_done, bus.bist_fail, bus.fail_addr, bus.fail_elem}), 64'(0));
    rst_n = 1'b1;
    settle();

    // Fault-free memory.
    start_run(0, 0, 0, 1'b0, e, r);
    wait_done();
    chk("tp_clean_done_edge", 64'(edge_cnt - e), 64'(162));
    chk("tp_clean_fail", 64'(bus.bist_fail), 64'(0));
    settle();

    // Stuck-at-1, bit 0, address 5.
    start_run(2, 5, 0, 1'b0, e, r);
    wait_done();
`ifdef MBIST_STOP_ON_FAIL_EN
    chk("tp_sa1_done_edge", 64'(edge_cnt - e), 64'(29));
`else
    chk("tp_sa1_done_edge", 64'(edge_cnt - e), 64'(162));
`endif
    chk("tp_sa1_result", 64'({bus.bist_fail, bus.fail_addr, bus.fail_elem}),
        64'({1'b1, 4'd5, 3'd1}));
    settle();

    // Stuck-at-0, bit 1, address 12: first caught by M2, M4 must not overwrite.
    start_run(1, 12, 1, 1'b0, e, r);
    wait_done();
    chk("tp_sa0_result", 64'({bus.bist_fail, bus.fail_addr, bus.fail_elem}),
        64'({1'b1, 4'd12, 3'd2}));
    settle();

    // Reset during M3 aborts immediately, then a full restart.
`ifdef MBIST_STOP_ON_FAIL_EN
    start_run(0, 0, 0, 1'b0, e, r);
`else
    start_run(2, 5, 0, 1'b0, e, r);
`endif
    k = $urandom_range(0, 31);
    while (edge_cnt < e + 1 + 80 + k) @(negedge clk);
    op_q.delete();
    res_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_abort", 64'({bus.mode, bus.bist_cs, bus.bist_done, bus.bist_fail}), 64'(0));
    rst_n = 1'b1;
    settle();
    start_run(0, 0, 0, 1'b0, e, r);
    wait_done();
    chk("restart_done_edge", 64'(edge_cnt - e), 64'(162));
    settle();

    // Hold start through DONE, drop it, then restart.
    start_run(2, 5, 0, 1'b1, e, r);
    wait_done();
    repeat (20) @(negedge clk);
    chk("hold_stays_done", 64'({bus.bist_done, bus.mode, bus.bist_cs}), 64'({1'b1, 1'b0, 1'b0}));
    bus.bist_start = 1'b0;
    settle();
    chk("idle_clears_done", 64'(bus.bist_done), 64'(0));
    chk("idle_keeps_results", 64'({bus.bist_fail, bus.fail_addr, bus.fail_elem}),
        64'({r.fail, r.faddr, r.felem}));
    start_run(0, 0, 0, 1'b0, e, r);
    wait_done();
    chk("rerun_clean_fail", 64'(bus.bist_fail), 64'(0));
    settle();

    // Randomized faults and idle gaps.
    repeat (6) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_run(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
                int'($urandom_range(0, DW - 1)), 1'b0, e, r);
      wait_done();
      settle();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(op_q.size() + res_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbist_ctrl.md
# mbist_ctrl

March C- memory BIST controller that generates the `bist_*` request stream and the `mode` select consumed by the function/BIST mode mux in front of the memory under test. It sequences all six March C- elements over the full address space and checks read data returned by the memory. It reports pass/fail plus the first failing address and element. It sits directly upstream of the mode mux and observes the memory read port downstream of it.

## Interface
- `pADDR_WIDTH`, 4, memory address width; N = 2^pADDR_WIDTH words.
- `pDATA_WIDTH`, 2, memory data width; backgrounds are all-0 / all-1 of this width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, synchronous and active-low.
- `bist_start`  in  1  level request to run the test, sampled in IDLE and DONE.
- `mem_dout`  in  pDATA_WIDTH  memory read data; valid the cycle after a read request.
- `mode`  out  1  mux select; 1 = BIST owns the memory.
- `bist_cs`  out  1  chip select for the current BIST operation.
- `bist_we`  out  1  write enable; 1 = write, 0 = read (qualified by `bist_cs`).
- `bist_addr`  out  pADDR_WIDTH  operation address.
- `bist_pat`  out  pDATA_WIDTH  write data; all-0 or all-1.
- `bist_done`  out  1  test finished (level).
- `bist_fail`  out  1  sticky mismatch flag for the current or last run.
- `fail_addr`  out  pADDR_WIDTH  address of the first mismatching read.
- `fail_elem`  out  3  March element index (0..5) of the first mismatch.

## Operation
- Elements, one operation per clock, no bubbles:
  - M0: ascending w0.
  - M1: ascending (r0, w1).
  - M2: ascending (r1, w0).
  - M3: descending (r0, w1).
  - M4: descending (r1, w0).
  - M5: ascending r0.
- Total operation cycles: 10N; 160 at the defaults.
- States:
  - IDLE: `mode`=0, `bist_cs`=0. Go to RUN when `bist_start`=1. Entering RUN clears `bist_fail`, `fail_addr` and `fail_elem`.
  - RUN: `mode`=1 and `bist_cs`=1 every cycle.
    - Counters: element index (3 bits), op index (1 bit), address counter.
    - Ascending elements start at 0 and end at N-1. Descending elements start at N-1 and end at 0.
    - When the address counter hits the last address, it reloads for the next element; no wrap-around overshoot.
    - After the final M5 read, go to DRAIN.
  - DRAIN: one cycle, `mode`=1, `bist_cs`=0. Compares the last read. Then go to DONE.
  - DONE: `bist_done`=1, `mode`=0, `bist_cs`=0; results held.
    - `bist_start`=0 returns to IDLE and clears `bist_done`; results are kept.
    - `bist_start` still 1 stays in DONE; there is no auto-restart.
- Compare: each read registers its expected value, address and element. On the next edge, `mem_dout` is compared bitwise against the expected value.
- Mismatch (any bit): set `bist_fail`. `fail_addr` and `fail_elem` are captured only on the first mismatch of a run.
- `bist_pat` equals the expected value during reads and the write value during writes. `bist_addr` and `bist_pat` hold their last value when `bist_cs`=0.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, all outputs 0.
- Reset mid-RUN aborts at that edge: `mode` drops to 0 the following cycle, with no drain.
- `bist_start` sampled at edge E: first operation (M0 w0 at address 0) is presented in the cycle after E, with `mode`=1.
- Last M5 read is in cycle E+10N; DRAIN is cycle E+10N+1; `bist_done` is 1 from edge E+10N+2. At the defaults that is edge E+162.
- Memory read latency is exactly 1 cycle. The compare for the read in cycle t uses `mem_dout` at the edge ending cycle t+1.
- All outputs are decoded from registered state only; there is no combinational path from `mem_dout` or `bist_start` to any output.

## Configuration
- `MBIST_STOP_ON_FAIL_EN`
  - Defined: the edge that detects the first mismatch forces DONE. `bist_done`=1 and `mode`=0 from the next cycle. The one operation issued in the detecting cycle completes unchecked.
  - Undefined: the run always completes all 10N operations. `bist_fail` stays sticky, and `fail_addr`/`fail_elem` hold the first failure.

## Test plan
- Fault-free memory model, defaults, start pulse at edge E:
  - 160 `bist_cs` cycles, of which 80 have `bist_we`=1.
  - Address sequence: 0..15 for M0-M2, 15..0 for M3-M4, 0..15 for M5.
  - `bist_done` at E+162 with `bist_fail`=0.
- Stuck-at-1 on bit 0 of address 5 (stop-on-fail undefined):
  - `bist_fail`=1, `fail_addr`=5, `fail_elem`=1.
  - Run still completes at E+162.
- Same stuck-at-1 fault with `MBIST_STOP_ON_FAIL_EN` defined:
  - The M1 r0 at address 5 is in cycle E+27; `bist_done`=1 from edge E+29.
  - `fail_addr`=5, `fail_elem`=1.
- Stuck-at-0 on bit 1 of address 12:
  - First mismatch is the M2 r1 read → `fail_addr`=12, `fail_elem`=2.
  - A later M4 failure does not overwrite the captured values.
- Assert `rst_n`=0 during M3 → next cycle: `mode`=0, `bist_cs`=0, `bist_done`=0, `bist_fail`=0. A restart then runs the full 162-cycle sequence.
- Hold `bist_start`=1 through DONE → no restart. Drop it → IDLE with `bist_done`=0 and results held. Raise it again → results cleared and a new run starts.
